i2s_tx_serializer: RTL

Downstream consumer of the divided audio bit clock. Runs on the 50 MHz `clk_in` system clock, samples the divider's output as `bclk_in`, and serializes stereo PCM samples into a Philips-I2S stream (`i2s_bclk`, `i2s_lrclk`, `i2s_dout`) for the DE2 audio codec DAC. Samples enter through a one-deep holding register with a valid/ready handshake. Frame timing is counted entirely from detected `bclk_in` edges.

---
 rtl/i2s_tx_serializer_if.sv | 25 ++
 rtl/i2s_tx_serializer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_serializer_if.sv
// Sample-pair handshake between an audio source and the I2S serializer.
// The source drives a left/right pair with s_valid; the serializer returns s_ready
// while its holding register is empty.
interface i2s_tx_serializer_if #(
    parameter int unsigned DATA_W = 16
) ();
    logic [DATA_W-1:0] l_data;
    logic [DATA_W-1:0] r_data;
    logic              s_valid;
    logic              s_ready;

    modport master (
        output l_data,
        output r_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  l_data,
        input  r_data,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/i2s_tx_serializer.sv
// Philips-I2S transmitter for the codec DAC.
// bclk_in comes from the clock divider and is treated as a data signal: it is
// synchronized into clk_in, and every frame boundary is derived from its falling
// edges. A one-deep holding register decouples the sample source from the frame
// timing; a second register pair holds the frame currently being shifted out.
module i2s_tx_serializer #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned SLOT_BITS = 32
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               bclk_in,
    i2s_tx_serializer_if.slave s_if,
    output logic               i2s_bclk,
    output logic               i2s_lrclk,
    output logic               i2s_dout,
    output logic               frame_strobe,
    output logic               underrun
);
    localparam int unsigned FrameBits = 2 * SLOT_BITS;
    localparam int unsigned CntW      = $clog2(FrameBits);
    localparam int unsigned SlotIdxW  = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;

    localparam logic [CntW-1:0]     CntMax   = CntW'(FrameBits - 1);
    localparam logic [CntW-1:0]     SlotCnt  = CntW'(SLOT_BITS);
    localparam logic [SlotIdxW-1:0] SlotLast = SlotIdxW'(SLOT_BITS - 1);

    // Bit-clock synchronizer and edge detector
    logic s1_q;
    logic s2_q;
    logic bclk_d_q;
    logic fall_evt;

    // Frame position
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic [CntW-1:0] cnt_next;
    logic            xfer;

    // Sample buffering
    logic [DATA_W-1:0] l_hold_q, l_hold_d;
    logic [DATA_W-1:0] r_hold_q, r_hold_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] l_act_q, l_act_d;
    logic [DATA_W-1:0] r_act_q, r_act_d;
    logic              accept;

    // Serial bit selection
    logic                 right_slot;
    logic [SlotIdxW-1:0]  slot_idx;
    logic [SLOT_BITS-1:0] slot_l;
    logic [SLOT_BITS-1:0] slot_r;
    logic [SLOT_BITS-1:0] slot_word;
    logic                 ser_bit;

    // Registered outputs
    logic lrclk_q, lrclk_d;
    logic dout_q, dout_d;
    logic strobe_q, strobe_d;
    logic underrun_q, underrun_d;

    // Two-flop synchronizer plus one delay stage for edge detection
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            bclk_d_q <= 1'b0;
        end else begin
            s1_q     <= bclk_in;
            s2_q     <= s1_q;
            bclk_d_q <= s2_q;
        end
    end

    // Falling edge of the synchronized bit clock; rising edges are ignored
    assign fall_evt = ~s2_q & bclk_d_q;

    // Next frame position and the frame-transfer condition (position wraps to 0)
    always_comb begin
        cnt_next = (bit_cnt_q == CntMax) ? '0 : bit_cnt_q + 1'b1;
        xfer     = fall_evt && (cnt_next == '0);
    end

    // Choose the outgoing bit. The current count is the position of the bit that
    // goes out on this fall, so word select naturally leads the MSB by one BCLK.
    // Samples are MSB-aligned in a zero-padded slot so positions past DATA_W read 0.
    always_comb begin
        right_slot = (bit_cnt_q >= SlotCnt);
        slot_idx   = right_slot ? SlotIdxW'(bit_cnt_q - SlotCnt) : SlotIdxW'(bit_cnt_q);
        slot_l     = '0;
        slot_r     = '0;
        slot_l[SLOT_BITS-1 -: DATA_W] = l_act_q;
        slot_r[SLOT_BITS-1 -: DATA_W] = r_act_q;
        slot_word  = right_slot ? slot_r : slot_l;
        ser_bit    = slot_word[SlotLast - slot_idx];
    end

    assign accept = s_if.s_valid & ~hold_full_q;

    // Next-state for counter, outputs and the two buffer stages. A transfer reads
    // hold as it stood before this cycle; a same-cycle acceptance then refills it.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        lrclk_d     = lrclk_q;
        dout_d      = dout_q;
        strobe_d    = 1'b0;
        underrun_d  = 1'b0;
        l_hold_d    = l_hold_q;
        r_hold_d    = r_hold_q;
        hold_full_d = hold_full_q;
        l_act_d     = l_act_q;
        r_act_d     = r_act_q;

        if (fall_evt) begin
            bit_cnt_d = cnt_next;
            lrclk_d   = (cnt_next >= SlotCnt);
            dout_d    = ser_bit;
        end

        if (xfer) begin
            strobe_d = 1'b1;
            if (hold_full_q) begin
                l_act_d     = l_hold_q;
                r_act_d     = r_hold_q;
                hold_full_d = 1'b0;
            end else begin
                // Nothing queued: the next frame carries silence
                l_act_d    = '0;
                r_act_d    = '0;
                underrun_d = 1'b1;
            end
        end

        if (accept) begin
            l_hold_d    = s_if.l_data;
            r_hold_d    = s_if.r_data;
            hold_full_d = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q   <= '0;
            lrclk_q     <= 1'b0;
            dout_q      <= 1'b0;
            strobe_q    <= 1'b0;
            underrun_q  <= 1'b0;
            l_hold_q    <= '0;
            r_hold_q    <= '0;
            hold_full_q <= 1'b0;
            l_act_q     <= '0;
            r_act_q     <= '0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            lrclk_q     <= lrclk_d;
            dout_q      <= dout_d;
            strobe_q    <= strobe_d;
            underrun_q  <= underrun_d;
            l_hold_q    <= l_hold_d;
            r_hold_q    <= r_hold_d;
            hold_full_q <= hold_full_d;
            l_act_q     <= l_act_d;
            r_act_q     <= r_act_d;
        end
    end

    assign s_if.s_ready = ~hold_full_q;
    assign i2s_bclk     = bclk_d_q;
    assign i2s_lrclk    = lrclk_q;
    assign i2s_dout     = dout_q;
    assign frame_strobe = strobe_q;
    assign underrun     = underrun_q;

endmodule
